// File: rtl/mcs4_pkg.sv
// rtl/mcs4_pkg.sv - shared MCS-4 bus phase encoding and ROM I/O opcodes
package mcs4_pkg;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } phase_t;

  localparam logic [3:0] OP_WRR = 4'h2;
  localparam logic [3:0] OP_RDR = 4'hA;

endpackage

// File: rtl/test_rom_if.sv
// rtl/test_rom_if.sv - CPU nibble bus plus Wishbone backdoor seen by the program ROM
interface test_rom_if;

  logic [3:0]  data_i;
  logic [3:0]  data_o;
  logic        data_en;
  logic        cmd_n;
  logic [31:0] wb_data_i;
  logic [31:0] wb_addr_i;
  logic        wb_cyc_i;
  logic        wb_strobe_i;
  logic        wb_we_i;
  logic [31:0] wb_data_o;
  logic        wb_ack_o;

  modport master (
    output data_i, cmd_n, wb_data_i, wb_addr_i, wb_cyc_i, wb_strobe_i, wb_we_i,
    input  data_o, data_en, wb_data_o, wb_ack_o
  );

  modport slave (
    input  data_i, cmd_n, wb_data_i, wb_addr_i, wb_cyc_i, wb_strobe_i, wb_we_i,
    output data_o, data_en, wb_data_o, wb_ack_o
  );

endinterface

// File: rtl/mcs4_cycle_counter.sv
// rtl/mcs4_cycle_counter.sv - eight-phase bus cycle counter shared with test_ram
module mcs4_cycle_counter
  import mcs4_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   halt,
  output phase_t cycle
);

  phase_t cycle_next;

  always_ff @(posedge clock) begin
    if (reset) cycle <= A1;
    else       cycle <= cycle_next;
  end

  // 3-bit arithmetic wraps X3 back to A1 on its own
  always_comb begin
    cycle_next = cycle;
    if (!halt) cycle_next = phase_t'(cycle + 3'd1);
  end

endmodule

// File: rtl/test_rom.sv
// rtl/test_rom.sv - 4001-style program ROM with Wishbone backdoor; TEST_ROM_IO_PORT_EN adds SRC/WRR/RDR port
module test_rom
  import mcs4_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'd0,
  parameter int         DEPTH   = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt,
  input  logic [3:0] in_port,
  output logic [3:0] out,
  test_rom_if.slave  bus
);

  phase_t     cycle;
  logic [3:0] addr_lo;
  logic [3:0] addr_hi;
  logic       fetch_sel;
  logic [7:0] rom_o;
  logic [7:0] mem [DEPTH];
  logic       wb_take;
  logic       rdr_drive;

  mcs4_cycle_counter u_cycle (
    .clock (clock),
    .reset (reset),
    .halt  (halt),
    .cycle (cycle)
  );

  // Backdoor only in X3 or while halted, so it never collides with the A3 fetch
  assign wb_take = !reset && (cycle == X3 || halt) &&
                   bus.wb_cyc_i && bus.wb_strobe_i && !bus.wb_ack_o;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_lo   <= 4'h0;
      addr_hi   <= 4'h0;
      fetch_sel <= 1'b0;
      rom_o     <= 8'h00;
    end else if (!halt) begin
      case (cycle)
        A1: addr_lo <= bus.data_i;
        A2: addr_hi <= bus.data_i;
        A3: begin
          fetch_sel <= (bus.data_i == CHIP_ID);
          rom_o     <= mem[{addr_hi, addr_lo}];
        end
        default: ;
      endcase
    end
  end

  // Program memory deliberately has no reset so a loaded image survives it
  always_ff @(posedge clock) begin
    if (wb_take && bus.wb_we_i) mem[bus.wb_addr_i[9:2]] <= bus.wb_data_i[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.wb_ack_o  <= 1'b0;
      bus.wb_data_o <= 32'h0;
    end else begin
      bus.wb_ack_o <= wb_take;
      if (wb_take) bus.wb_data_o <= {24'h0, mem[bus.wb_addr_i[9:2]]};
    end
  end

`ifdef TEST_ROM_IO_PORT_EN
  logic       cmd;
  logic       io_sel;
  logic       inst_active;
  logic [3:0] inst;
  logic [3:0] out_q;

  assign cmd = !bus.cmd_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_sel      <= 1'b0;
      inst_active <= 1'b0;
      inst        <= 4'h0;
      out_q       <= 4'h0;
    end else if (!halt) begin
      if (cycle == X2 && cmd) io_sel <= (bus.data_i == CHIP_ID);
      if (cycle == M2 && cmd && io_sel) begin
        inst        <= bus.data_i;
        inst_active <= 1'b1;
      end
      if (cycle == X3 && !cmd) inst_active <= 1'b0;
      if (cycle == X2 && inst_active && inst == OP_WRR) out_q <= bus.data_i;
    end
  end

  assign out       = out_q;
  assign rdr_drive = (cycle == X2) && inst_active && (inst == OP_RDR);

  logic unused_bits;
  assign unused_bits = ^{bus.wb_addr_i[31:10], bus.wb_addr_i[1:0], bus.wb_data_i[31:8]};
`else
  assign out       = 4'h0;
  assign rdr_drive = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.wb_addr_i[31:10], bus.wb_addr_i[1:0], bus.wb_data_i[31:8],
                         in_port, bus.cmd_n};
`endif

  // Reset gates the drive immediately rather than waiting for the clearing edge
  always_comb begin
    bus.data_o  = 4'h0;
    bus.data_en = 1'b0;
    if (!reset) begin
      if ((cycle == M1 || cycle == M2) && fetch_sel) begin
        bus.data_en = 1'b1;
        bus.data_o  = (cycle == M1) ? rom_o[7:4] : rom_o[3:0];
      end else if (rdr_drive) begin
        bus.data_en = 1'b1;
        bus.data_o  = in_port;
      end
    end
  end

endmodule

// File: tb/tb_test_rom.sv
// tb/tb_test_rom.sv - scoreboard bench for test_rom fetch, I/O port, backdoor and reset
module tb_test_rom;

  localparam logic [3:0] CID = 4'h3;
`ifdef TEST_ROM_IO_PORT_EN
  localparam bit IO = 1'b1;
`else
  localparam bit IO = 1'b0;
`endif

  typedef struct {
    int           when;
    logic [127:0] nm;
    logic [3:0]   d;
    logic         en;
    bit           co;
    logic [3:0]   o;
    bit           cw;
    logic [31:0]  wd;
  } bexp_t;

  typedef struct {
    logic [31:0] d;
    bit          chk;
  } wexp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       halt;
  logic [3:0] in_port;
  logic [3:0] out_w;

  test_rom_if bus ();

  test_rom #(.CHIP_ID(CID)) dut (
    .clock   (clock),
    .reset   (reset),
    .halt    (halt),
    .in_port (in_port),
    .out     (out_w),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int    cyc_no = 0;
  int    base = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    waited;
  logic  prev_ack = 1'b0;
  bexp_t bq[$];
  wexp_t wbq[$];
  bexp_t be;
  wexp_t we_e;

  always @(posedge clock) cyc_no <= cyc_no + 1;

  function automatic void check(input logic [127:0] nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic exp_bus(input int p, input logic [127:0] nm, input logic [3:0] d, input logic en,
                         input bit co, input logic [3:0] o, input bit cw, input logic [31:0] wd);
    bexp_t e;
    e.when = base + p; e.nm = nm; e.d = d; e.en = en;
    e.co = co; e.o = o; e.cw = cw; e.wd = wd;
    bq.push_back(e);
  endtask

  task automatic phase(input logic [3:0] n, input logic c);
    bus.data_i = n;
    bus.cmd_n  = c;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic [31:0] nib, input logic [7:0] cmn);
    for (int p = 0; p < 8; p++) phase(nib[4*(7-p) +: 4], cmn[7-p]);
  endtask

  task automatic wb_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [31:0] exp, input bit chk, output int n);
    wexp_t e;
    e.d = exp; e.chk = chk;
    wbq.push_back(e);
    bus.wb_addr_i = a; bus.wb_we_i = we; bus.wb_data_i = wd;
    bus.wb_cyc_i = 1'b1; bus.wb_strobe_i = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      n = i + 1;
      if (bus.wb_ack_o) break;
    end
    if (!bus.wb_ack_o) begin
      n_checks++; n_fail++;
      $display("FAIL wb_timeout: got no ack after %0d cycles for addr %0h", n, a);
    end
    bus.wb_cyc_i = 1'b0; bus.wb_strobe_i = 1'b0; bus.wb_we_i = 1'b0;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    while (bq.size() > 0 && bq[0].when < cyc_no) begin
      n_checks++; n_fail++;
      $display("FAIL %0s: never sampled, due cycle %0d now %0d", bq[0].nm, bq[0].when, cyc_no);
      void'(bq.pop_front());
    end
    while (bq.size() > 0 && bq[0].when == cyc_no) begin
      be = bq.pop_front();
      check({be.nm, "_d"}, bus.data_o, be.d);
      check({be.nm, "_en"}, bus.data_en, be.en);
      if (be.co) check({be.nm, "_out"}, out_w, be.o);
      if (be.cw) begin
        check({be.nm, "_wbd"}, bus.wb_data_o, be.wd);
        check({be.nm, "_ack"}, bus.wb_ack_o, 0);
      end
    end
    if (bus.wb_ack_o) begin
      check("wb_ack_width", prev_ack, 0);
      if (wbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wb_unexpected_ack: got ack 1 expected 0");
      end else begin
        we_e = wbq.pop_front();
        if (we_e.chk) check("wb_rdata", bus.wb_data_o, we_e.d);
      end
    end
    prev_ack = bus.wb_ack_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; halt = 1'b1; in_port = 4'h0;
    bus.data_i = 4'h0; bus.cmd_n = 1'b1;
    bus.wb_data_i = 32'h0; bus.wb_addr_i = 32'h0;
    bus.wb_cyc_i = 1'b0; bus.wb_strobe_i = 1'b0; bus.wb_we_i = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    base = cyc_no;
    exp_bus(0, "reset", 4'h0, 1'b0, 1, 4'h0, 1, 32'h0);
    wb_access(32'h0D0, 1'b1, 32'hD7, 32'h0, 0, waited);
    wb_access(32'h3FC, 1'b1, 32'h11, 32'h0, 0, waited);
    wb_access(32'h3FC, 1'b1, 32'hAB, 32'h11, 1, waited);
    wb_access(32'h3FC, 1'b0, 32'h0, 32'hAB, 1, waited);
    wb_access(32'h0D0, 1'b0, 32'h0, 32'hD7, 1, waited);
    halt = 1'b0;

    // fetch 0x34 from this chip
    base = cyc_no;
    exp_bus(0, "t1_a1", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    exp_bus(3, "t1_m1", 4'hD, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(4, "t1_m2", 4'h7, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(6, "t1_x2", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    run({4'h4, 4'h3, CID, 20'h0}, 8'hFF);

    // other chip selected
    base = cyc_no;
    exp_bus(3, "t2_m1", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    exp_bus(4, "t2_m2", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    run({4'h4, 4'h3, CID + 4'h1, 20'h0}, 8'hFF);

    // SRC selects this chip
    base = cyc_no;
    exp_bus(6, "src_x2", 4'h0, 1'b0, 1, 4'h0, 0, 0);
    run({4'h0, 4'h0, CID + 4'h1, 4'h0, 4'h0, 4'h0, CID, 4'h0}, 8'b1111_1101);

    // WRR 9
    base = cyc_no;
    exp_bus(6, "wrr_pre", 4'h0, 1'b0, 1, 4'h0, 0, 0);
    exp_bus(7, "wrr_out", 4'h0, 1'b0, 1, IO ? 4'h9 : 4'h0, 0, 0);
    run({4'h0, 4'h0, CID + 4'h1, 4'h0, 4'h2, 4'h0, 4'h9, 4'h0}, 8'b1111_0111);

    // RDR with in_port 6
    in_port = 4'h6;
    base = cyc_no;
    exp_bus(5, "rdr_x1", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    exp_bus(6, "rdr_x2", IO ? 4'h6 : 4'h0, IO, 0, 4'h0, 0, 0);
    exp_bus(7, "rdr_x3", 4'h0, 1'b0, 1, IO ? 4'h9 : 4'h0, 0, 0);
    run({4'h0, 4'h0, CID + 4'h1, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0}, 8'b1111_0111);

    // SRC to another chip, then WRR must be ignored
    run({4'h0, 4'h0, CID + 4'h1, 4'h0, 4'h0, 4'h0, CID + 4'h2, 4'h0}, 8'b1111_1101);
    base = cyc_no;
    exp_bus(6, "desel_x2", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    exp_bus(7, "desel_out", 4'h0, 1'b0, 1, IO ? 4'h9 : 4'h0, 0, 0);
    run({4'h0, 4'h0, CID + 4'h1, 4'h0, 4'h2, 4'h0, 4'h5, 4'h0}, 8'b1111_0111);

    // halt held in M1 for two edges
    base = cyc_no;
    exp_bus(3, "halt_m1a", 4'hD, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(4, "halt_m1b", 4'hD, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(5, "halt_m1c", 4'hD, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(6, "halt_m2", 4'h7, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(7, "halt_x1", 4'h0, 1'b0, 0, 4'h0, 0, 0);
    phase(4'h4, 1'b1); phase(4'h3, 1'b1); phase(CID, 1'b1);
    halt = 1'b1;
    phase(4'h0, 1'b1); phase(4'h0, 1'b1);
    halt = 1'b0;
    for (int p = 0; p < 5; p++) phase(4'h0, 1'b1);

    // top address 0xFF
    base = cyc_no;
    exp_bus(3, "wrap_m1", 4'hA, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(4, "wrap_m2", 4'hB, 1'b1, 0, 4'h0, 0, 0);
    run({4'hF, 4'hF, CID, 20'h0}, 8'hFF);

    // reset in M1
    base = cyc_no;
    exp_bus(3, "rst_m1", 4'h0, 1'b0, 1, IO ? 4'h9 : 4'h0, 0, 0);
    exp_bus(4, "rst_after", 4'h0, 1'b0, 1, 4'h0, 1, 32'h0);
    phase(4'hF, 1'b1); phase(4'hF, 1'b1); phase(CID, 1'b1);
    reset = 1'b1;
    phase(4'h0, 1'b1);
    reset = 1'b0;
    base = cyc_no;
    exp_bus(3, "post_m1", 4'hA, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(4, "post_m2", 4'hB, 1'b1, 0, 4'h0, 0, 0);
    exp_bus(7, "post_x3", 4'h0, 1'b0, 1, 4'h0, 0, 0);
    run({4'hF, 4'hF, CID, 20'h0}, 8'hFF);

    // running bus: backdoor waits for X3
    wb_access(32'h0D0, 1'b0, 32'h0, 32'hD7, 1, waited);
    check("wb_x3_wait", waited, 8);

    repeat (3) @(posedge clock);
    #1;
    check("bus_queue_empty", bq.size(), 0);
    check("wb_queue_empty", wbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_rom.md
# test_rom

Program ROM stage for the MCS-4 bus: the 4001-style chip directly upstream of `test_ram` on the shared 4-bit bus. It captures the 8-bit program address in A1–A2, checks chip select in A3, and drives the fetched opcode in M1/M2. It also implements the ROM I/O port: SRC selection, WRR and RDR. A Wishbone backdoor loads and reads program bytes while the bus is idle or halted.

## Interface
Parameters:
- `CHIP_ID`, default 0: 4-bit chip number. Compared against the A3 nibble and the SRC high nibble.
- `DEPTH`, default 256: program bytes per chip. Fixed at 256; an 8-bit address.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `halt`  in  1  freezes all bus-side state; Wishbone remains live.
- `data_i`  in  4  bus nibble from the CPU.
- `data_o`  out  4  nibble driven onto the bus.
- `data_en`  out  1  bus drive enable.
- `cmd_n`  in  1  CM-ROM, active-low.
- `in_port`  in  4  external input port.
- `out`  out  4  registered output port.
- `wb_data_i`  in  32  backdoor write data.
- `wb_addr_i`  in  32  backdoor byte address.
- `wb_cyc_i`, `wb_strobe_i`, `wb_we_i`  in  1 each  Wishbone control.
- `wb_data_o`  out  32  backdoor read data.
- `wb_ack_o`  out  1  backdoor acknowledge.

## Operation
- **Cycle counter:** 3-bit `cycle`, reset 0, increments when `!halt`, wraps 7→0.
- **Phase mapping:** 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3. This is identical to the RAM counter, so the two stay lockstep from a common reset.
- **Fetch path:**
  - A1: `addr_lo <= data_i`.
  - A2: `addr_hi <= data_i`.
  - A3: `fetch_sel <= (data_i == CHIP_ID)`; `rom_o <= mem[{addr_hi,addr_lo}]`.
- **Opcode drive:**
  - M1: `data_o = rom_o[7:4]`, `data_en = fetch_sel`.
  - M2: `data_o = rom_o[3:0]`, `data_en = fetch_sel`.
- **SRC:**
  - X2 with `cmd` asserted: `io_sel <= (data_i == CHIP_ID)`. This clears `io_sel` on a mismatch.
  - X3: no action; the ROM ignores the character nibble.
- **I/O instruction:**
  - M2 with `cmd` and `io_sel`: `inst <= data_i`, `inst_active <= 1`.
  - X3 without `cmd`: `inst_active <= 0`.
- **Execute in X2 with `inst_active`:**
  - `inst==0x2` (WRR): `out <= data_i`.
  - `inst==0xA` (RDR): `data_o = in_port`, `data_en = 1`.
  - Any other code: no bus drive.
- **Bus idle:** `data_o = 0` whenever `data_en = 0`.
- **Reset values:** `cycle` 0, `addr` 0, `fetch_sel` 0, `io_sel` 0, `inst` 0, `inst_active` 0, `rom_o` 0, `out` 0, `wb_ack_o` 0, `wb_data_o` 0.
- **Memory and reset:** program memory is NOT cleared by reset, so a loaded program survives it.
- **Halt:** freezes the counter and all bus registers; `data_o`/`data_en` hold their combinational values.

## Timing
- Fetch latency: address complete at the A2 edge; byte registered at the A3 edge; nibbles valid throughout M1 and M2.
- Wishbone access:
  - Accepted only when `cycle==7` or `halt`, and only when `wb_cyc_i && wb_strobe_i && !wb_ack_o`.
  - `wb_ack_o` pulses for exactly one cycle.
  - Back-to-back strobes take at least 2 cycles per access.
- Wishbone write: `mem[wb_addr_i[9:2]] <= wb_data_i[7:0]`.
- Wishbone read: `wb_data_o <= {24'h0, mem[wb_addr_i[9:2]]}`. On a write the read data returns the pre-write byte.
- A backdoor write in X3 lands before the next A3 read, so the next fetch sees the new byte.
- Address 0xFF wraps to 0x00 on the CPU side; no side effect.
- Reset mid-instruction: all state returns to reset values on the next edge, and `data_en` drops the same cycle.
- Simultaneous events (Wishbone access in X3 while a bus cycle completes): both proceed; there is no conflict on the memory port because the CPU read occurs in A3.

## Configuration
- `TEST_ROM_IO_PORT_EN` defined: SRC/WRR/RDR logic present as described.
- Undefined:
  - `io_sel`, `inst` and `inst_active` are removed.
  - `out` is tied 0 and `in_port` is ignored.
  - `data_en` is asserted only in M1/M2 for fetch.

## Structure
- Shared package `mcs4_pkg` holds:
  - Phase constants `A1..X3`.
  - I/O opcodes `OP_WRR=4'h2`, `OP_RDR=4'hA`.
- Sub-module `mcs4_cycle_counter`: 3-bit counter with reset/halt. It is reused by `test_ram` and this block.

## Test plan
- Backdoor-load `mem[0x34]=0xD7`. Drive A1=4, A2=3, A3=`CHIP_ID` → `data_o`=D, `data_en`=1 in M1; `data_o`=7, `data_en`=1 in M2.
- Same fetch with A3=`CHIP_ID`+1 → `data_en`=0 in both M1 and M2.
- SRC X2 nibble=`CHIP_ID` with `cmd_n`=0; M2 `cmd_n`=0, `data_i`=2; X2 `data_i`=9 → `out`=9 after the X2 edge.
- After SRC selects, `in_port`=6 and the next instruction is 0xA → `data_o`=6, `data_en`=1 in X2 only.
- Assert `halt`, write `wb_addr_i`=0x3FC, `wb_data_i`=0xAB → one-cycle ack; a read of 0x3FC returns 0x000000AB.
- Assert `reset` during M1 → `data_en`=0 and `out`=0 next cycle; memory still returns 0xAB at byte 0xFF.
